wishbone_arbiter: RTL and testbench
===================================

# wishbone_arbiter

Two-master, one-slave Wishbone arbiter that sits directly downstream of the CPU's two `wishbone_bus_if` instances: m0 is the instruction-side interface and m1 is the data-side interface. It connects both to the single shared memory/peripheral slave. Grant is round-robin on ties and is held until the transaction completes. A per-grant watchdog terminates any slave cycle that is never acknowledged, so a dead slave cannot hang the pipeline's stall logic.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, cycles without slave ack before forced termination (1..2^TO_W-1)
- TO_W, 8, watchdog counter width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m0_addr_i / m1_addr_i  in  ADDR_W  master address
- m0_data_i / m1_data_i  in  DATA_W  master write data
- m0_cyc_i / m1_cyc_i  in  1  master cycle
- m0_stb_i / m1_stb_i  in  1  master strobe
- m0_we_i / m1_we_i  in  1  master write enable
- m0_sel_i / m1_sel_i  in  4  master byte selects
- m0_data_o / m1_data_o  out  DATA_W  read data returned to the master
- m0_ack_o / m1_ack_o  out  1  acknowledge to the master
- s_addr_o, s_data_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  ADDR_W/DATA_W/4/1/1/1  slave-side bus
- s_data_i  in  DATA_W  slave read data
- s_ack_i  in  1  slave acknowledge
- grant_o  out  2  one-hot current grant: 01=m0, 10=m1, 00=none
- timeout_o  out  1  one-cycle pulse when the watchdog terminates a transaction

## Operation
- Registered state: `state` (IDLE, GNT0, GNT1), `last` (last granted master, 1 bit), and `wd` (TO_W counter).
- Reset values: state=IDLE, last=1, wd=0. While the bus is idle, all slave outputs, both acks, both data outputs, grant_o and timeout_o are 0.
- A master requests when `cyc_i & stb_i` = 1.
- IDLE:
  - Only m0 requests -> GNT0.
  - Only m1 requests -> GNT1.
  - Both request -> grant the master that is not `last`. After reset m0 wins the first tie.
  - On entering a grant state: wd<=0, last<=granted index.
- GNTx:
  - Slave outputs are a combinational copy of master x's inputs.
  - mx_ack_o = s_ack_i. The other master's ack is 0.
  - Both m0_data_o and m1_data_o are driven with s_data_i while granted, and with 0 otherwise.
- Exit from GNTx:
  - s_ack_i=1 -> IDLE at the next edge.
  - Master x drops cyc_i without ack (flush abandon) -> IDLE at the next edge. Slave cyc/stb follow the master low in that same cycle.
  - Ack and cyc drop in the same cycle count as a completed ack.
- Watchdog:
  - In GNTx with no ack, wd increments each cycle.
  - In the cycle where wd==TIMEOUT and s_ack_i=0:
    - mx_ack_o=1 with mx_data_o=0
    - timeout_o=1
    - s_cyc_o=s_stb_o=0
    - next state IDLE
  - A real ack in that same cycle wins: normal completion, timeout_o=0.
- Requests from the non-granted master are held off with ack=0 until the grant is released. No preemption.
- Reset asserted mid-transaction forces state to IDLE immediately (asynchronous), so slave outputs drop to 0 within the same cycle.

## Timing
- Grant latency: a request sampled at edge N gives grant_o and s_cyc_o high from cycle N+1.
- With a zero-wait slave (ack in cycle N+1), master ack is in cycle N+1 and state returns to IDLE at edge N+2. Minimum 2 cycles per transaction.
- With a slave that has k wait states, ack arrives in cycle N+1+k.
- Earliest new grant after release: 1 IDLE cycle, then the next grant.
- Two continuously requesting masters alternate strictly: m0, m1, m0, …
- Ack-path is purely combinational: s_ack_i -> mx_ack_o and s_data_i -> mx_data_o. There is no added register stage.
- Timeout fires in cycle N+1+TIMEOUT relative to grant edge N.

## Test plan
- Reset, then m0 read at addr 0x0000_0100, slave acks 1 cycle later with 0x1234_5678 -> s_addr_o=0x100, m0_ack_o=1, m0_data_o=0x12345678, m1_ack_o=0, grant_o 01 then 00.
- m0 and m1 request in the same cycle after reset, both held for 4 transactions each, zero-wait slave -> grant order m0, m1, m0, m1…; m1 write data 0xCAFE_F00D and sel 4'b1111 appear on s_data_o/s_sel_o only while grant_o=10.
- m1 granted and slave inserts 3 wait states while m0 requests -> m0_ack_o stays 0 throughout; m0 is granted in the second cycle after m1's ack.
- Slave never acks with TIMEOUT=8 -> in cycle 9 after grant: timeout_o=1, m0_ack_o=1, m0_data_o=0, s_cyc_o=0; next cycle IDLE and timeout_o=0.
- m0 granted, m0 drops cyc_i (flush) before ack -> s_cyc_o=0 in the same cycle, no ack to m0, and m1's pending request is granted 2 cycles later.
- rst asserted asynchronously mid-transaction in GNT1 -> s_cyc_o, s_stb_o and grant_o go to 0 before the next clock edge; after release, the first tie goes to m0.

Source files
------------

// File: rtl/wishbone_arbiter.sv
// Two-master / one-slave Wishbone arbiter with round-robin tie break,
// grant held until ack or abandon, and a per-grant slave watchdog.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   m0_*_i / m1_*_i       master requests (addr, data, cyc, stb, we, sel)
//   m0_*_o / m1_*_o       read data and ack back to each master
//   s_*_o / s_*_i         shared slave bus (muxed request, read data, ack)
//   grant_o               one-hot grant: 01=m0, 10=m1, 00=none
//   timeout_o             one-cycle pulse when the watchdog ends a cycle
module wishbone_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,

    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,

    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    output logic [3:0]        s_sel_o,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i,

    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_e          state_q, state_d;
    logic            last_q,  last_d;
    logic [TO_W-1:0] wd_q,    wd_d;

    logic req0, req1;
    logic gnt0, gnt1;
    logic own_cyc;
    logic to_hit;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    assign own_cyc = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);

    // A real ack in the limit cycle wins; an abandoned cycle is not
    // reported as a timeout since the master no longer waits for it.
    assign to_hit = own_cyc & ~s_ack_i & (wd_q == TO_LIM);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                // last_q==1 means m1 went last, so m0 wins a tie
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                    wd_d    = '0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                    wd_d    = '0;
                end
            end
            GNT0: begin
                if (s_ack_i || !m0_cyc_i || to_hit)
                    state_d = IDLE;
                else
                    wd_d = wd_q + 1'b1;
            end
            GNT1: begin
                if (s_ack_i || !m1_cyc_i || to_hit)
                    state_d = IDLE;
                else
                    wd_d = wd_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        s_addr_o  = '0;
        s_data_o  = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_data_o = '0;
        m1_data_o = '0;
        if (gnt0) begin
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i & ~to_hit;
            s_stb_o  = m0_stb_i & ~to_hit;
            m0_ack_o = s_ack_i | to_hit;
        end else if (gnt1) begin
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i & ~to_hit;
            s_stb_o  = m1_stb_i & ~to_hit;
            m1_ack_o = s_ack_i | to_hit;
        end
        if (gnt0 || gnt1) begin
            m0_data_o = (gnt0 && to_hit) ? '0 : s_data_i;
            m1_data_o = (gnt1 && to_hit) ? '0 : s_data_i;
        end
    end

    assign grant_o   = {gnt1, gnt0};
    assign timeout_o = to_hit;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Randomized and directed bench for wishbone_arbiter against a
// transaction-level reference model of ownership, tie break and watchdog.
module tb_wishbone_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [3:0]  sel  [2];
    logic [31:0] m0_data_o, m1_data_o;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [31:0] s_dat;
    logic        s_ack;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int checks = 0;
    int fails  = 0;

    // model: owner 0=none, 1=m0, 2=m1; age=cycles spent in current grant
    int   owner;
    int   mlast;
    int   age;
    logic pack [2];

    always #5 clk = ~clk;

    wishbone_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(addr[0]), .m0_data_i(wdat[0]), .m0_cyc_i(cyc[0]),
        .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_addr_i(addr[1]), .m1_data_i(wdat[1]), .m1_cyc_i(cyc[1]),
        .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_data_i(s_dat), .s_ack_i(s_ack),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner   = 0;
        mlast   = 1;
        age     = 0;
        pack[0] = 1'b0;
        pack[1] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // check all outputs against the model, then advance the model
    task automatic eval();
        int   o;
        int   m;
        logic to;
        #4;
        o  = owner;
        m  = (o == 0) ? 0 : o - 1;
        to = (o != 0) && cyc[m] && !s_ack && (age == TO);
        chk("grant", grant_o, (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00);
        chk("s_cyc", s_cyc_o, (o != 0) && cyc[m] && !to);
        chk("s_stb", s_stb_o, (o != 0) && stb[m] && !to);
        chk("s_addr", s_addr_o, (o != 0) ? addr[m] : 32'h0);
        chk("s_wdat", s_data_o, (o != 0) ? wdat[m] : 32'h0);
        chk("s_sel", s_sel_o, (o != 0) ? sel[m] : 4'h0);
        chk("s_we", s_we_o, (o != 0) && we[m]);
        chk("m0_ack", m0_ack_o, (o == 1) && (s_ack || to));
        chk("m1_ack", m1_ack_o, (o == 2) && (s_ack || to));
        chk("m0_dat", m0_data_o,
            (o != 0 && !(o == 1 && to)) ? s_dat : 32'h0);
        chk("m1_dat", m1_data_o,
            (o != 0 && !(o == 2 && to)) ? s_dat : 32'h0);
        chk("tmo", timeout_o, to);
        pack[0] = (o == 1) && (s_ack || to);
        pack[1] = (o == 2) && (s_ack || to);
        if (o == 0) begin
            logic r0, r1;
            r0 = cyc[0] && stb[0];
            r1 = cyc[1] && stb[1];
            if (r0 && r1) owner = (mlast == 1) ? 1 : 2;
            else if (r0)  owner = 1;
            else if (r1)  owner = 2;
            if (owner != 0) begin
                mlast = owner - 1;
                age   = 0;
            end
        end else if (s_ack || !cyc[m] || to) begin
            owner = 0;
        end else begin
            age++;
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdat[i] = '0; cyc[i] = 1'b0;
            stb[i]  = 1'b0; we[i] = 1'b0; sel[i] = '0;
        end
        s_ack = 1'b0;
        s_dat = '0;
    endtask

    initial begin
        int q[$];
        int gc;
        int to_at;
        bit seen;
        logic pend [2];
        int dead;

        idle_inputs();
        model_reset();
        #3;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_scyc", s_cyc_o, 1'b0);
        chk("rst_ack0", m0_ack_o, 1'b0);
        chk("rst_tmo", timeout_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // tie after reset: strict alternation starting with m0
        tick();
        cyc[0] = 1; stb[0] = 1; addr[0] = 32'h40; sel[0] = 4'h3;
        cyc[1] = 1; stb[1] = 1; addr[1] = 32'h80; we[1] = 1;
        wdat[1] = 32'hCAFE_F00D; sel[1] = 4'hF;
        s_ack = 1; s_dat = 32'h5555_0000;
        eval();
        for (int c = 0; c < 16; c++) begin
            tick();
            s_dat = 32'h5555_0000 + c;
            eval();
            if (grant_o != 2'b00) q.push_back(int'(grant_o));
        end
        chk("rr_count", q.size(), 8);
        for (int i = 0; i < q.size() && i < 8; i++)
            chk("rr_order", q[i], (i % 2 == 0) ? 1 : 2);
        tick();
        idle_inputs();
        eval();
        tick();
        eval();

        // single m0 read, one wait-free ack
        tick();
        cyc[0] = 1; stb[0] = 1; addr[0] = 32'h100;
        eval();
        tick();
        s_ack = 1; s_dat = 32'h1234_5678;
        eval();
        chk("rd_addr", s_addr_o, 32'h100);
        chk("rd_ack0", m0_ack_o, 1'b1);
        chk("rd_dat0", m0_data_o, 32'h1234_5678);
        chk("rd_ack1", m1_ack_o, 1'b0);
        chk("rd_gnt", grant_o, 2'b01);
        tick();
        idle_inputs();
        eval();
        chk("rd_rel", grant_o, 2'b00);

        // dead slave: watchdog fires in granted cycle TO+1
        tick();
        cyc[0] = 1; stb[0] = 1; addr[0] = 32'h200;
        eval();
        gc = 0; to_at = 0; seen = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (seen) begin cyc[0] = 0; stb[0] = 0; end
            s_dat = 32'hDEAD_0000 + c;
            eval();
            if (grant_o == 2'b01) gc++;
            if (timeout_o && !seen) begin
                to_at = gc;
                seen  = 1;
                chk("to_ack0", m0_ack_o, 1'b1);
                chk("to_dat0", m0_data_o, 32'h0);
                chk("to_scyc", s_cyc_o, 1'b0);
            end
        end
        chk("to_cycle", to_at, TO + 1);

        // async reset in the middle of an m1 grant
        tick();
        idle_inputs();
        cyc[1] = 1; stb[1] = 1; addr[1] = 32'h300;
        eval();
        tick();
        eval();
        chk("ar_gnt1", grant_o, 2'b10);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_scyc", s_cyc_o, 1'b0);
        chk("ar_sstb", s_stb_o, 1'b0);
        chk("ar_gnt", grant_o, 2'b00);
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        model_reset();
        tick();
        cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1;
        eval();
        tick();
        eval();
        chk("ar_tie", grant_o, 2'b01);
        tick();
        idle_inputs();
        eval();

        // random traffic: wait states, abandons, dead-slave windows
        pend[0] = 0; pend[1] = 0; dead = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    if (pack[i] || $urandom_range(0, 29) == 0) pend[i] = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    addr[i] = $urandom;
                    wdat[i] = $urandom;
                    we[i]   = 1'($urandom_range(0, 1));
                    sel[i]  = 4'($urandom_range(0, 15));
                end
                cyc[i] = pend[i];
                stb[i] = pend[i];
            end
            if (dead > 0) dead--;
            else if ($urandom_range(0, 39) == 0) dead = 12;
            s_ack = (dead == 0) && ($urandom_range(0, 2) == 0);
            s_dat = $urandom;
            eval();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
